// File: rtl/nukv_predicate_packer_pkg.sv
// Shared constants, header field layout and FSM encoding for the predicate packer.
// Imported by the interface and the packer itself.
package nukv_predicate_packer_pkg;

   localparam int MAX_DEPTH       = 9;
   localparam int PRED_SLOT_WIDTH = 48;
   localparam int CFG_WORD_WIDTH  = 64;

   localparam int HDR_N_LSB    = 0;
   localparam int HDR_N_WIDTH  = 8;
   localparam int HDR_SCAN_BIT = 8;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_META  = 3'd1,
      ST_PRED  = 3'd2,
      ST_EMIT  = 3'd3,
      ST_DRAIN = 3'd4
   } state_t;

   function automatic int words_for_bits(input int bits);
      return (bits + CFG_WORD_WIDTH - 1) / CFG_WORD_WIDTH;
   endfunction

endpackage

// File: rtl/nukv_predicate_packer_if.sv
// Configuration word stream in, packed predicate set out.
// The master is the producer/consumer side; the packer is the slave.
interface nukv_predicate_packer_if
   import nukv_predicate_packer_pkg::*;
#(
   parameter int MEMORY_WIDTH = 512,
   parameter int META_WIDTH   = 96
);

   logic [CFG_WORD_WIDTH-1:0]          in_data;
   logic                               in_valid;
   logic                               in_last;
   logic                               in_ready;
   logic [META_WIDTH+MEMORY_WIDTH-1:0] pred_data;
   logic                               pred_valid;
   logic                               pred_scan;
   logic                               pred_ready;

   modport master (
      output in_data, in_valid, in_last,
      input  in_ready,
      input  pred_data, pred_valid, pred_scan,
      output pred_ready
   );

   modport slave (
      input  in_data, in_valid, in_last,
      output in_ready,
      output pred_data, pred_valid, pred_scan,
      input  pred_ready
   );

endinterface

// File: rtl/nukv_predicate_packer.sv
// Parses header/metadata/predicate word messages into one wide predicate set,
// holding it in the output register until the consumer takes it.
module nukv_predicate_packer
   import nukv_predicate_packer_pkg::*;
#(
   parameter int MEMORY_WIDTH = 512,
   parameter int META_WIDTH   = 96,
   parameter int PIPE_DEPTH   = 1
)(
   input  logic                      clk,
   input  logic                      rst,
   nukv_predicate_packer_if.slave    bus,
   output logic                      error_frame,
   output logic [15:0]               msg_count,
   output logic [15:0]               err_count
);

   localparam int PRED_W     = META_WIDTH + MEMORY_WIDTH;
   localparam int META_WORDS = words_for_bits(META_WIDTH);

   localparam logic [PRED_W-1:0] META_MASK  = {PRED_W{1'b1}} >> (PRED_W - META_WIDTH);
   localparam logic [PRED_W-1:0] WORD_ONES  = PRED_W'({CFG_WORD_WIDTH{1'b1}});
   localparam logic [PRED_W-1:0] SLOT_ONES  = PRED_W'({PRED_SLOT_WIDTH{1'b1}});
   localparam logic [PRED_W-1:0] SLOTS_MASK =
      PRED_W'({(PIPE_DEPTH*PRED_SLOT_WIDTH){1'b1}}) << META_WIDTH;

   state_t              state_r;
   state_t              state_nxt_s;
   logic [7:0]          n_r;
   logic                scan_r;
   logic [7:0]          word_cnt_r;
   logic [PRED_W-1:0]   pred_data_r;
   logic                pred_valid_r;
   logic                in_ready_r;
   logic [15:0]         msg_count_r;
   logic [15:0]         err_count_r;

   logic                accept_s;
   logic                xfer_s;
   logic                err_s;
   logic [7:0]          hdr_n_s;
   logic                last_meta_s;
   logic                last_pred_s;
   logic [15:0]         meta_shift_s;
   logic [15:0]         slot_shift_s;
   logic [PRED_W-1:0]   meta_mask_s;
   logic [PRED_W-1:0]   slot_mask_s;
   logic [PRED_W-1:0]   meta_merge_s;
   logic [PRED_W-1:0]   slot_merge_s;

   assign accept_s    = bus.in_valid & in_ready_r;
   assign xfer_s      = pred_valid_r & bus.pred_ready;
   assign hdr_n_s     = bus.in_data[HDR_N_LSB +: HDR_N_WIDTH];
   assign last_meta_s = (word_cnt_r == 8'(META_WORDS - 1));
   assign last_pred_s = (word_cnt_r == (n_r - 8'd1));

   // Word and slot writes are read-modify-write merges into the output register;
   // masks clip metadata overflow and anything beyond the configured slots.
   assign meta_shift_s = 16'(word_cnt_r) * 16'(CFG_WORD_WIDTH);
   assign slot_shift_s = 16'(META_WIDTH) + 16'(word_cnt_r) * 16'(PRED_SLOT_WIDTH);
   assign meta_mask_s  = (WORD_ONES << meta_shift_s) & META_MASK;
   assign slot_mask_s  = (SLOT_ONES << slot_shift_s) & SLOTS_MASK;
   assign meta_merge_s = (pred_data_r & ~meta_mask_s)
                       | ((PRED_W'(bus.in_data) << meta_shift_s) & meta_mask_s);
   assign slot_merge_s = (pred_data_r & ~slot_mask_s)
                       | ((PRED_W'(bus.in_data[PRED_SLOT_WIDTH-1:0]) << slot_shift_s) & slot_mask_s);

   // Next-state and error detection; a malformed word with in_last returns to IDLE, otherwise DRAIN.
   always_comb begin
      state_nxt_s = state_r;
      err_s       = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (accept_s) begin
               if (bus.in_last) begin
                  err_s       = 1'b1;
                  state_nxt_s = ST_IDLE;
               end else if (hdr_n_s > 8'(PIPE_DEPTH)) begin
                  err_s       = 1'b1;
                  state_nxt_s = ST_DRAIN;
               end else begin
                  state_nxt_s = ST_META;
               end
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_META: begin
            if (accept_s) begin
               if (last_meta_s && (n_r == 8'd0)) begin
                  if (bus.in_last) begin
                     state_nxt_s = ST_EMIT;
                  end else begin
                     err_s       = 1'b1;
                     state_nxt_s = ST_DRAIN;
                  end
               end else if (bus.in_last) begin
                  err_s       = 1'b1;
                  state_nxt_s = ST_IDLE;
               end else if (last_meta_s) begin
                  state_nxt_s = ST_PRED;
               end else begin
                  state_nxt_s = ST_META;
               end
            end else begin
               state_nxt_s = ST_META;
            end
         end
         ST_PRED: begin
            if (accept_s) begin
               if (last_pred_s) begin
                  if (bus.in_last) begin
                     state_nxt_s = ST_EMIT;
                  end else begin
                     err_s       = 1'b1;
                     state_nxt_s = ST_DRAIN;
                  end
               end else if (bus.in_last) begin
                  err_s       = 1'b1;
                  state_nxt_s = ST_IDLE;
               end else begin
                  state_nxt_s = ST_PRED;
               end
            end else begin
               state_nxt_s = ST_PRED;
            end
         end
         ST_EMIT: begin
            if (xfer_s) begin
               state_nxt_s = ST_IDLE;
            end else begin
               state_nxt_s = ST_EMIT;
            end
         end
         ST_DRAIN: begin
            if (accept_s && bus.in_last) begin
               state_nxt_s = ST_IDLE;
            end else begin
               state_nxt_s = ST_DRAIN;
            end
         end
         default: begin
            state_nxt_s = ST_IDLE;
         end
      endcase
   end

   // State register; handshake flags are registered from the next state so neither is combinational.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r      <= ST_IDLE;
         pred_valid_r <= 1'b0;
         in_ready_r   <= 1'b1;
      end else begin
         state_r      <= state_nxt_s;
         pred_valid_r <= (state_nxt_s == ST_EMIT);
         in_ready_r   <= (state_nxt_s != ST_EMIT);
      end
   end

   // Header fields, word counter and the predicate set itself.
   always_ff @(posedge clk) begin
      if (rst) begin
         n_r         <= 8'd0;
         scan_r      <= 1'b0;
         word_cnt_r  <= 8'd0;
         pred_data_r <= '0;
      end else if (accept_s && (state_r == ST_IDLE)) begin
         n_r         <= hdr_n_s;
         scan_r      <= bus.in_data[HDR_SCAN_BIT];
         word_cnt_r  <= 8'd0;
         pred_data_r <= '0;
      end else if (accept_s && (state_r == ST_META)) begin
         pred_data_r <= meta_merge_s;
         word_cnt_r  <= last_meta_s ? 8'd0 : (word_cnt_r + 8'd1);
      end else if (accept_s && (state_r == ST_PRED)) begin
         pred_data_r <= slot_merge_s;
         word_cnt_r  <= word_cnt_r + 8'd1;
      end
   end

   // Emitted/discarded message counters, free-running with natural wrap.
   always_ff @(posedge clk) begin
      if (rst) begin
         msg_count_r <= 16'd0;
         err_count_r <= 16'd0;
      end else begin
         if (xfer_s) begin
            msg_count_r <= msg_count_r + 16'd1;
         end
         if (err_s) begin
            err_count_r <= err_count_r + 16'd1;
         end
      end
   end

   assign error_frame    = err_s & ~rst;
   assign msg_count      = msg_count_r;
   assign err_count      = err_count_r;
   assign bus.in_ready   = in_ready_r;
   assign bus.pred_valid = pred_valid_r;
   assign bus.pred_data  = pred_data_r;
   assign bus.pred_scan  = scan_r;

endmodule

// File: doc/nukv_predicate_packer.md
NUKV_PREDICATE_PACKER -- requirements
Module: nukv_predicate_packer

Interface
REQ-001 Parameter MEMORY_WIDTH, default 512, value width of the downstream predicate bus.
REQ-002 Parameter META_WIDTH, default 96, metadata width carried with each predicate set.
REQ-003 Parameter PIPE_DEPTH, default 1, number of 48-bit predicate slots filled; legal range 1..9.
REQ-004 Port clk  input  1  single clock; all logic on rising edge.
REQ-005 Port rst  input  1  synchronous, active-high reset.
REQ-006 Port in_data  input  64  configuration word stream.
REQ-007 Port in_valid  input  1; in_last  input  1  marks final word of message; in_ready  output  1.
REQ-008 Port pred_data  output  META_WIDTH+MEMORY_WIDTH  packed predicate set.
REQ-009 Port pred_valid  output  1; pred_scan  output  1; pred_ready  input  1.
REQ-010 Port error_frame  output  1  one-cycle pulse per malformed message.
REQ-011 Port msg_count  output  16; err_count  output  16  emitted and discarded message counters.

Function
REQ-012 Word transfer occurs only when in_valid and in_ready are both 1; pred transfer only when pred_valid and pred_ready are both 1.
REQ-013 Message format: header word, then META_WORDS = ceil(META_WIDTH/64) metadata words, then N predicate words; in_last set on final word only.
REQ-014 Header: bits[7:0] = N, bit[8] = scan flag, bits[63:9] ignored.
REQ-015 Metadata words fill pred_data[META_WIDTH-1:0] low word first; excess bits of the last metadata word discarded.
REQ-016 Predicate word k (0-based) bits[47:0] fill pred_data[META_WIDTH+k*48 +: 48]; bits[63:48] ignored.
REQ-017 Slots k >= N, and all bits above META_WIDTH+PIPE_DEPTH*48, SHALL be zero (zero predicate = pass-all).
REQ-018 FSM states: IDLE, META, PRED, EMIT, DRAIN.
REQ-019 IDLE: on header accept, latch N and scan, clear output register, go META; if header has in_last, error.
REQ-020 META: accept META_WORDS words; after last one go PRED if N>0, else EMIT.
REQ-021 PRED: accept N words, then go EMIT.
REQ-022 N = 0 legal: message is header plus metadata only; emits all-zero predicate slots.
REQ-023 Error conditions: N > PIPE_DEPTH (detected at header); in_last before the expected final word; expected final word without in_last.
REQ-024 On error: error_frame pulses 1 cycle on the detecting cycle, err_count increments, nothing emitted; go IDLE if the detecting word had in_last, else DRAIN.
REQ-025 DRAIN: accept and discard words until in_last accepted, then IDLE; no further error pulse.
REQ-026 in_ready = 1 in IDLE, META, PRED, DRAIN; 0 in EMIT.
REQ-027 EMIT: pred_valid = 1 starting the cycle after the final word is accepted; pred_data and pred_scan stable until transfer.
REQ-028 On pred transfer: msg_count increments, state returns IDLE; next header accepted the following cycle.
REQ-029 pred_valid SHALL not depend combinationally on pred_ready; pred_ready low holds EMIT indefinitely.
REQ-030 Counters wrap 0xFFFF -> 0x0000.

Reset
REQ-031 rst SHALL force IDLE, pred_valid=0, pred_scan=0, pred_data=0, error_frame=0, msg_count=0, err_count=0, in_ready=1 next cycle.
REQ-032 rst mid-message or during EMIT SHALL discard the partial or pending set without emission or error pulse.

Structure
REQ-033 Shared package holds MAX_DEPTH=9, PRED_SLOT_WIDTH=48, CFG_WORD_WIDTH=64, header field offsets, and the FSM state encoding.
REQ-034 Single flat module; no sub-modules; output register is the only storage of the predicate set.

Verification
REQ-035 PIPE_DEPTH=3, N=2, scan=1, meta 0x0123.., preds 0xAAAA_0000_0001, 0xBBBB_0000_0002 -> one transfer, slots 0/1 as given, slot 2 zero, pred_scan=1, msg_count=1.
REQ-036 N=0 -> pred_valid one cycle after second metadata word, all slots zero, msg_count increments.
REQ-037 PIPE_DEPTH=2, N=3 with 6 words -> error_frame single pulse at header, all words consumed, no pred_valid, err_count=1.
REQ-038 N=2 with in_last on first predicate word -> error pulse that cycle, IDLE next, err_count=1; following valid message emitted normally.
REQ-039 pred_ready held 0 for 20 cycles during EMIT -> pred_valid and pred_data stable, in_ready=0 throughout; transfer on first pred_ready=1.
REQ-040 rst asserted during PRED, then a full valid message -> only the post-reset message emitted, counters count from 0.
